sqrt_result_fifo: RTL and testbench
===================================

SQRT_RESULT_FIFO -- requirements
Module: sqrt_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 valor_i  input  16  radicand presented to the upstream square-root unit, held stable while it computes.
REQ-005 done_i  input  1  upstream completion flag, level or pulse; a 0->1 transition marks a new result.
REQ-006 root_i  input  8  upstream root result, valid whenever done_i=1.
REQ-007 out_valid_o  output  1  head entry available.
REQ-008 out_ready_i  input  1  consumer accepts head entry.
REQ-009 out_root_o  output  8  head entry root.
REQ-010 out_rem_o  output  9  head entry remainder, valor - root^2, low 9 bits.
REQ-011 out_err_o  output  1  head entry failed the root consistency check.
REQ-012 count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 overflow_o  output  1  sticky flag: a result was dropped.

Function
REQ-014 Edge detect: done_q SHALL register done_i each cycle; capture SHALL occur in a cycle where done_i=1 and done_q=0.
REQ-015 On capture, one entry {root_i, rem, err} SHALL be written, using the valor_i and root_i values of that same cycle.
REQ-016 Check: sq = root_i*root_i (16 bit), sq1 = (root_i+1)^2 (17 bit); err = (sq > valor_i) or (sq1 <= valor_i).
REQ-017 rem SHALL be (valor_i - sq) truncated to 9 bits. It is meaningful only when err=0.
REQ-018 A captured entry SHALL appear on out_* with out_valid_o=1 in the cycle after capture. The latency from done_i edge to out_valid_o is 1 cycle when the FIFO was empty.
REQ-019 A pop SHALL occur when out_valid_o=1 and out_ready_i=1. The head SHALL advance at that edge.
REQ-020 out_root_o, out_rem_o and out_err_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-021 Capture while empty plus out_ready_i=1 SHALL NOT bypass the FIFO; the entry is popped at the earliest one cycle later.
REQ-022 Capture and pop in the same cycle: both SHALL take effect and count_o SHALL be unchanged. This applies when full as well.
REQ-023 Capture when full without a pop: the entry SHALL be dropped, overflow_o SHALL be set to 1 and stay 1 until reset, and stored entries SHALL be unchanged.
REQ-024 out_ready_i when empty SHALL be ignored, with no pointer or count change.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH. Full is count_o=DEPTH; empty is count_o=0.
REQ-026 With empty FIFO, out_root_o, out_rem_o and out_err_o SHALL be 0.

Reset
REQ-027 While rst_n=0 at a clock edge: pointers, count_o, out_valid_o and overflow_o SHALL be 0, and the FIFO SHALL be flushed.
REQ-028 done_q SHALL reset to 1, so that done_i held high across reset release produces no capture.
REQ-029 Reset asserted mid-operation SHALL discard all entries and any capture in that cycle.
REQ-030 Storage array contents need not be reset, but outputs SHALL obey REQ-026.

Structure
REQ-031 The shared package SHALL hold ROOT_W=8, VAL_W=16 and REM_W=9, plus a packed entry typedef {root, rem, err}.
REQ-032 The consistency check (REQ-016/017) SHALL be one combinational sub-module, sqrt_check, with inputs valor and root and outputs rem and err.
REQ-033 Storage and pointers SHALL stay in sqrt_result_fifo.

Verification
REQ-034 Single result: valor_i=200, root_i=14, done_i 0->1 with out_ready_i=0. Next cycle: out_valid_o=1, out_root_o=14, out_rem_o=4, out_err_o=0, count_o=1.
REQ-035 Bad root: valor_i=100, root_i=11, done edge. Response: out_err_o=1. Repeat with root_i=9: out_err_o=1. Repeat with root_i=10: out_err_o=0, out_rem_o=0.
REQ-036 Boundary: valor_i=65535, root_i=255. Response: out_err_o=0, out_rem_o=510 (9'h1FE), with sq1=65536 computed without overflow.
REQ-037 Overflow (DEPTH=4): 5 done edges with roots 1..5 and out_ready_i=0. Response: count_o=4 and overflow_o=1; draining yields roots 1,2,3,4 in order, then out_valid_o=0.
REQ-038 Full plus simultaneous pop: with the FIFO full and out_ready_i=1, a new edge in the same cycle gives count_o=4, and order is preserved.
REQ-039 Reset: with done_i held 1 through rst_n 0->1, no capture occurs. Reset during a partially full FIFO gives count_o=0, out_valid_o=0 and overflow_o=0 the next cycle.

Source files
------------

// File: rtl/sqrt_result_fifo_pkg.sv
// Shared widths and entry layout for the square-root result FIFO.
// Imported by the checker and the FIFO top.
package sqrt_result_fifo_pkg;

    localparam int ROOT_W = 8;
    localparam int VAL_W  = 16;
    localparam int REM_W  = 9;

    typedef struct packed {
        logic [ROOT_W-1:0] root;
        logic [REM_W-1:0]  rem;
        logic              err;
    } entry_t;

endpackage

// File: rtl/sqrt_result_fifo_check.sv
// Combinational root consistency check.
// Flags roots that are not floor(sqrt(valor)) and forms the remainder.
module sqrt_check
    import sqrt_result_fifo_pkg::*;
(
    input  logic [VAL_W-1:0]  valor,
    input  logic [ROOT_W-1:0] root,
    output logic [REM_W-1:0]  rem,
    output logic              err
);

    logic [VAL_W-1:0] sq;
    logic [VAL_W:0]   sq1;
    logic [VAL_W:0]   r1;

    // Squares are widened so (255+1)^2 = 65536 does not wrap.
    always_comb begin
        r1  = {{(VAL_W-ROOT_W){1'b0}}, 1'b0, root} + 1'b1;
        sq  = {{(VAL_W-ROOT_W){1'b0}}, root}
            * {{(VAL_W-ROOT_W){1'b0}}, root};
        sq1 = r1 * r1;
        err = (sq > valor) || (sq1 <= {1'b0, valor});
        rem = REM_W'(valor - sq);
    end

endmodule

// File: rtl/sqrt_result_fifo.sv
// Captures square-root results on done rising edges into a FIFO.
// Each entry carries the root, its remainder and a check flag.
module sqrt_result_fifo
    import sqrt_result_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [VAL_W-1:0]         valor_i,
    input  logic                     done_i,
    input  logic [ROOT_W-1:0]        root_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ROOT_W-1:0]        out_root_o,
    output logic [REM_W-1:0]         out_rem_o,
    output logic                     out_err_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem [DEPTH];
    entry_t          new_e;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            done_q;
    logic            overflow;
    logic            capture;
    logic            pop;
    logic            full;
    logic            write;
    logic [REM_W-1:0] rem;
    logic            err;

    sqrt_check u_check (
        .valor (valor_i),
        .root  (root_i),
        .rem   (rem),
        .err   (err)
    );

    // Capture/pop qualification and head presentation.
    always_comb begin
        capture = done_i && !done_q;
        full    = (count == FULL_CNT);
        pop     = (count != '0) && out_ready_i;
        write   = capture && (!full || pop);
        new_e   = '{root: root_i, rem: rem, err: err};
        head    = mem[rd_ptr];
        if (count == '0) head = '0;
    end

    // Pointers, occupancy, edge detector and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done_q   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            done_q <= done_i;
            if (write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (write && !pop)      count <= count + 1'b1;
            else if (!write && pop) count <= count - 1'b1;
            if (capture && full && !pop) overflow <= 1'b1;
        end
    end

    // Entry storage; contents are don't-care until pointed to.
    always_ff @(posedge clk) begin
        if (rst_n && write) mem[wr_ptr] <= new_e;
    end

    assign out_valid_o = (count != '0);
    assign out_root_o  = head.root;
    assign out_rem_o   = head.rem;
    assign out_err_o   = head.err;
    assign count_o     = count;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_sqrt_result_fifo.sv
// Directed bench for sqrt_result_fifo (DEPTH=4).
// Expected values are hand-computed constants.
module tb_sqrt_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] valor_i;
    logic        done_i;
    logic [7:0]  root_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_root_o;
    logic [8:0]  out_rem_o;
    logic        out_err_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    sqrt_result_fifo #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valor_i     (valor_i),
        .done_i      (done_i),
        .root_i      (root_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_root_o  (out_root_o),
        .out_rem_o   (out_rem_o),
        .out_err_o   (out_err_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One done pulse; leaves done_i low for a cycle so the next edge is seen.
    task automatic push(input logic [15:0] v, input logic [7:0] r);
        valor_i = v;
        root_i  = r;
        done_i  = 1'b1;
        tick();
        done_i  = 1'b0;
        tick();
    endtask

    task automatic pop1();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        valor_i = '0;
        root_i = '0;
        done_i = 1'b1;
        out_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_root", out_root_o, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_high_nocap", count_o, 0);
        done_i = 1'b0;
        tick();

        push(16'd200, 8'd14);
        chk("single_valid", out_valid_o, 1);
        chk("single_root", out_root_o, 14);
        chk("single_rem", out_rem_o, 4);
        chk("single_err", out_err_o, 0);
        chk("single_count", count_o, 1);
        pop1();
        chk("empty_valid", out_valid_o, 0);
        chk("empty_root", out_root_o, 0);
        chk("empty_rem", out_rem_o, 0);

        push(16'd100, 8'd11);
        chk("bad11_err", out_err_o, 1);
        pop1();
        push(16'd100, 8'd9);
        chk("bad9_err", out_err_o, 1);
        pop1();
        push(16'd100, 8'd10);
        chk("ok10_err", out_err_o, 0);
        chk("ok10_rem", out_rem_o, 0);
        pop1();
        push(16'd65535, 8'd255);
        chk("max_err", out_err_o, 0);
        chk("max_rem", out_rem_o, 9'h1FE);
        pop1();

        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("ready_empty_cnt", count_o, 0);

        for (int r = 1; r <= 5; r++) push(16'(r * r), 8'(r));
        chk("ovf_count", count_o, 4);
        chk("ovf_flag", overflow_o, 1);
        for (int r = 1; r <= 4; r++) begin
            chk("drain_root", out_root_o, r);
            chk("drain_err", out_err_o, 0);
            pop1();
        end
        chk("drain_empty", out_valid_o, 0);

        for (int r = 1; r <= 4; r++) push(16'(r * r), 8'(r));
        chk("full_count", count_o, 4);
        valor_i = 16'd25;
        root_i = 8'd5;
        done_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        done_i = 1'b0;
        out_ready_i = 1'b0;
        chk("fullpop_count", count_o, 4);
        chk("fullpop_head", out_root_o, 2);
        tick();
        for (int r = 2; r <= 5; r++) begin
            chk("fullpop_order", out_root_o, r);
            pop1();
        end
        chk("fullpop_empty", count_o, 0);

        out_ready_i = 1'b1;
        valor_i = 16'd49;
        root_i = 8'd7;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("nobypass_cnt", count_o, 1);
        chk("nobypass_root", out_root_o, 7);
        tick();
        out_ready_i = 1'b0;
        chk("nobypass_pop", count_o, 0);

        push(16'd9, 8'd3);
        push(16'd16, 8'd4);
        chk("mid_count", count_o, 2);
        rst_n = 1'b0;
        valor_i = 16'd36;
        root_i = 8'd6;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        rst_n = 1'b1;
        chk("midrst_count", count_o, 0);
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_ovf", overflow_o, 0);
        tick();
        chk("midrst_after", count_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
